// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the 2-way data cache.
// Imported by the way array and the cache top.
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WB,
        REFILL,
        DONE
    } state_t;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: tag/valid/dirty/line storage.
// Async read and a single write port on the same index.
module dcache_way_array #(
    parameter int TAG_W  = 23,
    parameter int IDX_W  = 4,
    parameter int LINE_W = 256,
    parameter int SETS   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              we_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              wr_dirty_i,
    input  logic [LINE_W-1:0] wr_line_i,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_line_o
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_line_o  = line_q[idx_i];

    // Status bits: cleared by reset, every write makes the entry valid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= wr_dirty_i;
        end
    end

    // Tag and data payload need no reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[idx_i]  <= wr_tag_i;
            line_q[idx_i] <= wr_line_i;
        end
    end

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back/write-allocate data cache.
// True LRU per set, single-cycle hits, hit/miss counters.
module dcache_2way_top
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             p1_data_i,
    input  logic [ADDR_W-1:0]       p1_addr_i,
    input  logic                    p1_MemRead_i,
    input  logic                    p1_MemWrite_i,
    output logic [31:0]             p1_data_o,
    output logic                    p1_stall_o,
    input  logic [8*LINE_BYTES-1:0] mem_data_i,
    input  logic                    mem_ack_i,
    output logic [8*LINE_BYTES-1:0] mem_data_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic                    mem_enable_o,
    output logic                    mem_write_o,
    output logic [31:0]             hit_cnt_o,
    output logic [31:0]             miss_cnt_o
);

    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = OFF_W - 2;

    state_t state, state_n;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic              unused_ok;

    logic [1:0]        rd_valid;
    logic [1:0]        rd_dirty;
    logic [TAG_W-1:0]  rd_tag  [2];
    logic [LINE_W-1:0] rd_line [2];
    logic [1:0]        hit_w;
    logic [1:0]        we;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] wr_line;

    logic              hit, p1_req;
    logic              hit_fire, hit_wr, miss_fire, refill_fire;
    logic [SETS-1:0]   lru;
    logic              victim;
    logic              v_valid, v_dirty;
    logic [TAG_W-1:0]  v_tag;

    logic              mem_en_n, mem_wr_n;
    logic [ADDR_W-1:0] mem_addr_n;

    assign idx       = p1_addr_i[OFF_W +: IDX_W];
    assign tag       = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel      = p1_addr_i[OFF_W-1:2];
    assign unused_ok = ^p1_addr_i[1:0];

    assign p1_req      = p1_MemRead_i | p1_MemWrite_i;
    assign hit         = |hit_w;
    assign hit_fire    = (state == IDLE) & p1_req & hit;
    assign hit_wr      = hit_fire & p1_MemWrite_i;
    assign miss_fire   = (state == IDLE) & p1_req & ~hit;
    assign refill_fire = (state == REFILL) & mem_ack_i;

    assign p1_stall_o  = p1_req & (~hit | (state != IDLE));
    assign hit_line    = hit_w[1] ? rd_line[1] : rd_line[0];
    assign p1_data_o   = hit ? hit_line[{wsel, 5'b0} +: 32] : 32'd0;

    assign v_valid     = rd_valid[victim];
    assign v_dirty     = rd_dirty[victim];
    assign v_tag       = rd_tag[victim];
    assign mem_data_o  = rd_line[victim];

    // Both ways share one write bus; the enables pick the target way.
    always_comb begin
        wr_line = hit_line;
        wr_line[{wsel, 5'b0} +: 32] = p1_data_i;
        if (state == REFILL) wr_line = mem_data_i;
    end

    for (genvar k = 0; k < 2; k++) begin : g_way
        assign hit_w[k] = rd_valid[k] & (rd_tag[k] == tag);
        assign we[k]    = (hit_wr & hit_w[k]) |
                          (refill_fire & (victim == k[0]));

        dcache_way_array #(
            .TAG_W  (TAG_W),
            .IDX_W  (IDX_W),
            .LINE_W (LINE_W),
            .SETS   (SETS)
        ) u_way (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .idx_i      (idx),
            .we_i       (we[k]),
            .wr_tag_i   (tag),
            .wr_dirty_i (state != REFILL),
            .wr_line_i  (wr_line),
            .rd_valid_o (rd_valid[k]),
            .rd_dirty_o (rd_dirty[k]),
            .rd_tag_o   (rd_tag[k]),
            .rd_line_o  (rd_line[k])
        );
    end

    // Two ways must never both claim a hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) assert (hit_w != 2'b11);
    end

    // LRU points at the way to evict next; victim latched on a miss.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lru    <= '0;
            victim <= 1'b0;
        end else begin
            if (hit_fire) lru[idx] <= hit_w[0];
            if (miss_fire) begin
                if (!rd_valid[0])      victim <= 1'b0;
                else if (!rd_valid[1]) victim <= 1'b1;
                else                   victim <= lru[idx];
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (hit_fire && hit_cnt_o != '1)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss_fire && miss_cnt_o != '1)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end

    // FSM state and registered memory request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
        end else begin
            state        <= state_n;
            mem_enable_o <= mem_en_n;
            mem_write_o  <= mem_wr_n;
            mem_addr_o   <= mem_addr_n;
        end
    end

    // Next state and next memory request.
    always_comb begin
        state_n    = state;
        mem_en_n   = mem_enable_o;
        mem_wr_n   = mem_write_o;
        mem_addr_n = mem_addr_o;
        unique case (state)
            IDLE: begin
                if (miss_fire) state_n = MISS;
            end
            MISS: begin
                mem_en_n = 1'b1;
                if (v_valid && v_dirty) begin
                    state_n    = WB;
                    mem_wr_n   = 1'b1;
                    mem_addr_n = {v_tag, idx, {OFF_W{1'b0}}};
                end else begin
                    state_n    = REFILL;
                    mem_wr_n   = 1'b0;
                    mem_addr_n = {tag, idx, {OFF_W{1'b0}}};
                end
            end
            WB: begin
                if (mem_ack_i) begin
                    state_n    = REFILL;
                    mem_wr_n   = 1'b0;
                    mem_addr_n = {tag, idx, {OFF_W{1'b0}}};
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    state_n  = DONE;
                    mem_en_n = 1'b0;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
